// File: rtl/sa_pkg.sv
// sa_pkg: shared types, beat constants and the signed compare helper for the systolic result collector
package sa_pkg;
    localparam int DATA_W_DEF = 8;
    localparam logic [2:0] BEAT_POOL = 3'd4;
    localparam int BEATS_PER_TILE = 4;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, POOL} state_t;

    function automatic logic [DATA_W_DEF-1:0] signed_max2(input logic [DATA_W_DEF-1:0] a, input logic [DATA_W_DEF-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction
endpackage

// File: rtl/sa_result_collector_if.sv
// sa_result_collector_if: tile capture and byte-stream handshake between the array, collector and writeback
interface sa_result_collector_if #(parameter int DATA_W = 8);
    logic              res_valid;
    logic [DATA_W-1:0] res_c0;
    logic [DATA_W-1:0] res_c1;
    logic [DATA_W-1:0] res_c2;
    logic [DATA_W-1:0] res_c3;
    logic              res_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_idx;
    logic              out_last;

    modport master (
        output res_valid, res_c0, res_c1, res_c2, res_c3, out_ready,
        input  res_ready, out_valid, out_data, out_idx, out_last
    );
    modport slave (
        input  res_valid, res_c0, res_c1, res_c2, res_c3, out_ready,
        output res_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/sa_tile_fifo.sv
// sa_tile_fifo: synchronous tile FIFO; full/empty come straight from the occupancy register
module sa_tile_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          push_ok, pop_ok;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign rdata   = mem[rp];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) if (push_ok) mem[wp] <= wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop_ok) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/sa_result_collector.sv
// sa_result_collector: buffers 2x2 conv tiles and streams them bytewise; SA_MAXPOOL_EN appends a signed max-pool beat
module sa_result_collector
    import sa_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sa_result_collector_if.slave bus,
    output logic [CNT_W-1:0]     tile_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 overflow
);
    localparam int TW = 4 * DATA_W;
    localparam logic [1:0] LAST_DATA = 2'(BEATS_PER_TILE - 1);

    state_t            state, state_nx, after_tile;
    logic [TW-1:0]     rdata;
    logic [DATA_W-1:0] r [4];
    logic [DATA_W-1:0] w [4];
    logic [1:0]        beat;
    logic              full, empty, push, pop, hs, tile_done;

    sa_tile_fifo #(.W(TW), .DEPTH(DEPTH)) fifo (
        .clk, .rst, .push, .pop,
        .wdata({bus.res_c0, bus.res_c1, bus.res_c2, bus.res_c3}),
        .rdata, .full, .empty
    );

    assign push          = bus.res_valid && !full;
    assign pop           = state == LOAD;
    assign hs            = bus.out_valid && bus.out_ready;
    assign after_tile    = empty ? IDLE : LOAD;
    assign bus.res_ready = !full;

    always_comb for (int i = 0; i < 4; i++) r[i] = rdata[TW-1-DATA_W*i -: DATA_W];

`ifdef SA_MAXPOOL_EN
    logic [DATA_W-1:0] pool_max;
    assign tile_done = hs && state == POOL;
    always_ff @(posedge clk) if (pop) pool_max <= signed_max2(signed_max2(r[0], r[1]), signed_max2(r[2], r[3]));
`else
    assign tile_done = hs && beat == LAST_DATA;
`endif

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = after_tile;
            LOAD:    state_nx = SEND;
`ifdef SA_MAXPOOL_EN
            SEND:    state_nx = (hs && beat == LAST_DATA) ? POOL : SEND;
            POOL:    state_nx = hs ? after_tile : POOL;
`else
            SEND:    state_nx = tile_done ? after_tile : SEND;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
`ifdef SA_MAXPOOL_EN
        bus.out_valid = state == SEND || state == POOL;
        bus.out_data  = state == SEND ? w[beat] : state == POOL ? pool_max : '0;
        bus.out_idx   = state == SEND ? {1'b0, beat} : state == POOL ? BEAT_POOL : 3'd0;
        bus.out_last  = state == POOL;
`else
        bus.out_valid = state == SEND;
        bus.out_data  = state == SEND ? w[beat] : '0;
        bus.out_idx   = state == SEND ? {1'b0, beat} : 3'd0;
        bus.out_last  = state == SEND && beat == LAST_DATA;
`endif
    end

    always_ff @(posedge clk) if (pop) w <= r;

    // a push is judged against the registered full flag, so a same-cycle pop never rescues it
    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= '0;
            tile_cnt <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) beat <= '0;
            else if (hs && state == SEND) beat <= beat + 2'd1;
            if (tile_done) tile_cnt <= tile_cnt + CNT_W'(1);
            if (bus.res_valid && full) begin
                drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + CNT_W'(1);
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sa_result_collector.sv
// tb_sa_result_collector: queue-level model checked every cycle plus directed tiles with literal beat lists
module tb_sa_result_collector;
    localparam int DEPTH = 2;
`ifdef SA_MAXPOOL_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    typedef struct {
        logic [7:0] d;
        logic [2:0] idx;
        logic       last;
        int         cyc;
    } beat_t;

    logic clk = 0;
    logic rst = 1;
    logic [15:0] tile_cnt, drop_cnt;
    logic overflow;
    int errors = 0, checks = 0, cyc = 0;
    beat_t log_q[$];
    logic [7:0] exp_q[$];

    logic [31:0] m_q[$];
    logic [31:0] m_cur = '0;
    int m_phase = 0, m_beat = 0, m_tiles = 0, m_drops = 0;
    bit m_ovf = 0;

    always #5 clk = ~clk;

    sa_result_collector_if #(.DATA_W(8)) bus ();

    sa_result_collector #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .tile_cnt(tile_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m_byte(input logic [31:0] t, input int b);
        return 8'(t >> (8 * (3 - b)));
    endfunction

    function automatic logic [7:0] m_max(input logic [31:0] t);
        logic [7:0] m = m_byte(t, 0);
        for (int b = 1; b < 4; b++) if ($signed(m_byte(t, b)) > $signed(m)) m = m_byte(t, b);
        return m;
    endfunction

    // tile-level model: queue of buffered tiles, one load bubble, then NB beats gated by out_ready
    always @(posedge clk) begin : model
        bit full, ne;
        cyc++;
        full = m_q.size() == DEPTH;
        ne = m_q.size() != 0;
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_beat = 0; m_tiles = 0; m_drops = 0; m_ovf = 0;
        end else begin
            if (m_phase == 0) begin
                if (ne) m_phase = 1;
            end else if (m_phase == 1) begin
                m_cur = m_q.pop_front();
                m_beat = 0;
                m_phase = 2;
            end else if (bus.out_ready) begin
                m_beat++;
                if (m_beat == NB) begin
                    m_tiles = (m_tiles + 1) % 65536;
                    m_beat = 0;
                    m_phase = ne ? 1 : 0;
                end
            end
            if (bus.res_valid) begin
                if (full) begin
                    if (m_drops < 65535) m_drops++;
                    m_ovf = 1;
                end else m_q.push_back({bus.res_c0, bus.res_c1, bus.res_c2, bus.res_c3});
            end
        end
    end

    always @(negedge clk) begin
        chk("res_ready", bus.res_ready, m_q.size() < DEPTH);
        chk("out_valid", bus.out_valid, m_phase == 2);
        if (m_phase == 2) begin
            chk("out_data", bus.out_data, m_beat < 4 ? m_byte(m_cur, m_beat) : m_max(m_cur));
            chk("out_idx", bus.out_idx, m_beat);
            chk("out_last", bus.out_last, m_beat == NB - 1);
        end
        chk("tile_cnt", tile_cnt, m_tiles);
        chk("drop_cnt", drop_cnt, m_drops);
        chk("overflow", overflow, m_ovf);
        if (!rst && bus.out_valid && bus.out_ready)
            log_q.push_back('{bus.out_data, bus.out_idx, bus.out_last, cyc});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_tile(input logic [31:0] t);
        {bus.res_c0, bus.res_c1, bus.res_c2, bus.res_c3} = t;
        bus.res_valid = 1;
        tick();
        bus.res_valid = 0;
    endtask

    task automatic wait_beat(input int idx, input int lim);
        int k = 0;
        while (!(bus.out_valid && bus.out_idx == 3'(idx)) && k < lim) begin
            tick();
            k++;
        end
        chk("wait_beat reached", k < lim, 1);
    endtask

    task automatic add_tile(input logic [31:0] t, input logic [7:0] p);
        for (int b = 0; b < 4; b++) exp_q.push_back(t[31-8*b -: 8]);
`ifdef SA_MAXPOOL_EN
        exp_q.push_back(p);
`else
        if (p === 8'hxx) exp_q.push_back(p);
`endif
    endtask

    task automatic check_log(input string nm, input int start);
        chk({nm, " beat count"}, log_q.size() - start, exp_q.size());
        for (int i = 0; i < exp_q.size() && start + i < log_q.size(); i++) begin
            chk({nm, " data"}, log_q[start+i].d, exp_q[i]);
            chk({nm, " idx"}, log_q[start+i].idx, i % NB);
            chk({nm, " last"}, log_q[start+i].last, (i % NB) == NB - 1);
        end
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " res_ready"}, bus.res_ready, 1);
        chk({nm, " out_valid"}, bus.out_valid, 0);
        chk({nm, " out_data"}, bus.out_data, 0);
        chk({nm, " out_idx"}, bus.out_idx, 0);
        chk({nm, " out_last"}, bus.out_last, 0);
        chk({nm, " tile_cnt"}, tile_cnt, 0);
        chk({nm, " drop_cnt"}, drop_cnt, 0);
        chk({nm, " overflow"}, overflow, 0);
    endtask

    initial begin
        int n0;
        bus.res_valid = 0;
        {bus.res_c0, bus.res_c1, bus.res_c2, bus.res_c3} = '0;
        bus.out_ready = 1;
        tick(3);
        check_reset_outputs("reset");
        rst = 0;

        n0 = log_q.size();
        push_tile(32'h05FE0703);
        @(negedge clk) chk("t1 idle after push", bus.out_valid, 0);
        @(negedge clk) chk("t1 load bubble", bus.out_valid, 0);
        @(negedge clk) chk("t1 first beat at t+2", bus.out_valid, 1);
        tick(8);
        add_tile(32'h05FE0703, 8'h07);
        check_log("single", n0);
        chk("single tile_cnt", tile_cnt, 1);

        n0 = log_q.size();
        push_tile(32'h11223344);
        wait_beat(2, 20);
        bus.out_ready = 0;
        repeat (10) begin
            tick();
            chk("hold data", bus.out_data, 8'h33);
            chk("hold idx", bus.out_idx, 2);
        end
        bus.out_ready = 1;
        tick(8);
        add_tile(32'h11223344, 8'h44);
        check_log("backpressure", n0);

        bus.out_ready = 0;
        n0 = log_q.size();
        push_tile(32'hA0A1A2A3);
        push_tile(32'hB0B1B2B3);
        chk("full after two pushes", bus.res_ready, 0);
        push_tile(32'hC0C1C2C3);
        push_tile(32'hD0D1D2D3);
        chk("drop after LOAD pop", drop_cnt, 1);
        chk("overflow set", overflow, 1);
        tick(5);
        push_tile(32'hE0E1E2E3);
        chk("drop while stalled", drop_cnt, 2);
        bus.out_ready = 1;
        tick(25);
        add_tile(32'hA0A1A2A3, 8'hA3);
        add_tile(32'hB0B1B2B3, 8'hB3);
        add_tile(32'hD0D1D2D3, 8'hD3);
        check_log("overflow", n0);
        chk("overflow sticky", overflow, 1);
        chk("overflow tile_cnt", tile_cnt, 5);

        n0 = log_q.size();
        push_tile(32'h01020304);
        wait_beat(1, 20);
        push_tile(32'h05060708);
        tick(20);
        add_tile(32'h01020304, 8'h04);
        add_tile(32'h05060708, 8'h08);
        check_log("b2b", n0);
        if (log_q.size() >= n0 + 2 * NB)
            chk("b2b one bubble", log_q[n0+NB].cyc - log_q[n0+NB-1].cyc, 2);
        chk("b2b tile_cnt", tile_cnt, 7);

        push_tile(32'h21222324);
        push_tile(32'h31323334);
        wait_beat(2, 20);
        rst = 1;
        tick();
        check_reset_outputs("mid reset");
        rst = 0;
        n0 = log_q.size();
        tick(15);
        chk("no beats after reset", log_q.size(), n0);
        chk("idle after reset", bus.out_valid, 0);

        n0 = log_q.size();
        push_tile(32'h8081FF90);
        tick(12);
        add_tile(32'h8081FF90, 8'hFF);
        check_log("negative", n0);
        chk("negative tile_cnt", tile_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
